// File: rtl/ula_sequenciador.sv
// Operand sequencer and result register for the 8-bit ALU: collects A, B and F
// from switches on load presses, captures the ALU result and counts operations.
//
// state   | meaning
// WAIT_A  | waiting for load press to capture operand A
// WAIT_B  | waiting for load press to capture operand B
// WAIT_OP | waiting for load press to capture operation code F
// EXEC    | single cycle while the ALU settles on the new A/B/F
// SHOW    | result/flag held for display; next load restarts with A
module ula_sequenciador #(
  parameter int N_BITS   = 8,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic [N_BITS-1:0]   data_in,
  input  logic [1:0]          op_in,
  input  logic [N_BITS-1:0]   alu_saida,
  input  logic                alu_flag,
  output logic [N_BITS-1:0]   A,
  output logic [N_BITS-1:0]   B,
  output logic [1:0]          F,
  output logic [N_BITS-1:0]   result,
  output logic                flag,
  output logic                result_valid,
  output logic [2:0]          state,
  output logic [CNT_BITS-1:0] op_count
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'b000,
    WAIT_B  = 3'b001,
    WAIT_OP = 3'b010,
    EXEC    = 3'b011,
    SHOW    = 3'b100
  } state_t;

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   a_q, a_d;
  logic [N_BITS-1:0]   b_q, b_d;
  logic [1:0]          f_q, f_d;
  logic [N_BITS-1:0]   result_q, result_d;
  logic                flag_q, flag_d;
  logic                valid_q, valid_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                load_q, load_d;
  logic                load_ev;

  assign load_ev = load & ~load_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    f_d      = f_q;
    result_d = result_q;
    flag_d   = flag_q;
    valid_d  = valid_q;
    count_d  = count_q;
    load_d   = load;

    case (state_q)
      WAIT_A: if (load_ev) begin
        a_d     = data_in;
        state_d = WAIT_B;
      end
      WAIT_B: if (load_ev) begin
        b_d     = data_in;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (load_ev) begin
        f_d     = op_in;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_saida;
        flag_d   = alu_flag;
        valid_d  = 1'b1;
        count_d  = count_q + CNT_BITS'(1);
        state_d  = SHOW;
      end
      SHOW: if (load_ev) begin
        a_d     = data_in;
        valid_d = 1'b0;
        state_d = WAIT_B;
      end
      default: state_d = WAIT_A;
    endcase

    // Soft clear overrides any capture this cycle but keeps the operation count.
    if (clear) begin
      state_d  = WAIT_A;
      a_d      = '0;
      b_d      = '0;
      f_d      = '0;
      result_d = '0;
      flag_d   = 1'b0;
      valid_d  = 1'b0;
      count_d  = count_q;
      load_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_A;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f_q      <= f_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      load_q   <= load_d;
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign F            = f_q;
  assign result       = result_q;
  assign flag         = flag_q;
  assign result_valid = valid_q;
  assign state        = state_q;
  assign op_count     = count_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Self-checking bench for ula_sequenciador: the bench plays the ALU and keeps a
// cycle-level reference model of the operand-collection sequence.
module tb_ula_sequenciador;

  logic       clk = 1'b0;
  logic       reset, clear, load;
  logic [7:0] data_in;
  logic [1:0] op_in;
  logic [7:0] alu_saida;
  logic       alu_flag;
  logic [7:0] A, B, result;
  logic [1:0] F;
  logic       flag, result_valid;
  logic [2:0] state;
  logic [3:0] op_count;

  int tests_run = 0;
  int tests_failed = 0;

  ula_sequenciador #(.N_BITS(8), .CNT_BITS(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .data_in(data_in), .op_in(op_in),
    .alu_saida(alu_saida), .alu_flag(alu_flag),
    .A(A), .B(B), .F(F), .result(result), .flag(flag),
    .result_valid(result_valid), .state(state), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: AND, OR, ADD (flag = carry), SUB (flag = borrow); logic ops flag zero result.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    logic [8:0] r;
    case (f)
      2'b00: begin r[7:0] = a & b; r[8] = (r[7:0] == 8'h00); end
      2'b01: begin r[7:0] = a | b; r[8] = (r[7:0] == 8'h00); end
      2'b10: r = {1'b0, a} + {1'b0, b};
      default: begin r[7:0] = a - b; r[8] = (a < b); end
    endcase
    return r;
  endfunction

  always_comb {alu_flag, alu_saida} = alu_fn(A, B, F);

  // Reference model. phase: 0..2 = operands collected so far, 3 = executing, 4 = showing.
  int         m_phase;
  logic [7:0] m_a, m_b, m_res;
  logic [1:0] m_f;
  logic       m_flag, m_valid, m_loadq;
  int         m_cnt;

  function automatic logic [34:0] model_vec();
    return {m_a, m_b, m_f, m_res, m_flag, m_valid, 3'(m_phase), 4'(m_cnt % 16)};
  endfunction

  logic [34:0] obs;
  assign obs = {A, B, F, result, flag, result_valid, state, op_count};

  task automatic model_step(input logic r, input logic c, input logic l, input logic [7:0] d, input logic [1:0] o);
    logic [8:0] alu;
    bit ev;
    ev = l && !m_loadq;
    if (r || c) begin
      m_phase = 0; m_a = 0; m_b = 0; m_f = 0; m_res = 0; m_flag = 0; m_valid = 0; m_loadq = 0;
      if (r) m_cnt = 0;
      return;
    end
    m_loadq = l;
    if (m_phase == 3) begin
      alu = alu_fn(m_a, m_b, m_f);
      m_res = alu[7:0]; m_flag = alu[8]; m_valid = 1; m_cnt = (m_cnt + 1) % 16; m_phase = 4;
    end else if (ev) begin
      if (m_phase == 0 || m_phase == 4) begin m_a = d; m_valid = 0; m_phase = 1; end
      else if (m_phase == 1) begin m_b = d; m_phase = 2; end
      else begin m_f = o; m_phase = 3; end
    end
  endtask

  task automatic tick(input logic r, input logic c, input logic l, input logic [7:0] d, input logic [1:0] o);
    reset = r; clear = c; load = l; data_in = d; op_in = o;
    @(posedge clk);
    model_step(r, c, l, d, o);
    #1;
  endtask

  task automatic press(input logic [7:0] d, input logic [1:0] o);
    tick(0, 0, 1, d, o);
    tick(0, 0, 0, $urandom_range(0, 255), 2'($urandom_range(0, 3)));
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 8'h00, 2'b00);
    tick(1, 0, 0, 8'h00, 2'b00);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 8'h00, 2'b00);
      tests_run++;
      if (obs !== 35'h0) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs, 35'h0);
      end
    end
  endtask

  task automatic test_basic();
    press(8'h05, 2'b00);
    press(8'h03, 2'b00);
    tick(0, 0, 1, 8'h00, 2'b10);
    tests_run++;
    if (result_valid !== 1'b0 || state !== 3'b011) begin
      tests_failed++;
      $display("FAIL basic_exec: got valid=%b state=%b expected valid=0 state=011", result_valid, state);
    end
    tick(0, 0, 0, 8'h00, 2'b00);
    tests_run++;
    if (A !== 8'h05 || B !== 8'h03 || F !== 2'b10 || result !== 8'h08 || flag !== 1'b0 ||
        result_valid !== 1'b1 || op_count !== 4'd1 || state !== 3'b100) begin
      tests_failed++;
      $display("FAIL basic_show: got A=%h B=%h F=%b res=%h flag=%b v=%b cnt=%0d st=%b expected 05 03 10 08 0 1 1 100",
               A, B, F, result, flag, result_valid, op_count, state);
    end
    tests_run++;
    if (obs !== model_vec()) begin
      tests_failed++;
      $display("FAIL basic_model: got %h expected %h", obs, model_vec());
    end
  endtask

  task automatic test_show_reload();
    press(8'hF0, 2'b00);
    tests_run++;
    if (A !== 8'hF0 || result_valid !== 1'b0 || state !== 3'b001 || result !== 8'h08) begin
      tests_failed++;
      $display("FAIL show_reload: got A=%h v=%b st=%b res=%h expected F0 0 001 08", A, result_valid, state, result);
    end
    press(8'h0F, 2'b00);
    tick(0, 0, 1, 8'h00, 2'b00);
    tick(0, 0, 0, 8'h00, 2'b00);
    tests_run++;
    if (result !== 8'h00 || op_count !== 4'd2 || result_valid !== 1'b1 || obs !== model_vec()) begin
      tests_failed++;
      $display("FAIL show_second_op: got res=%h cnt=%0d v=%b vec=%h expected 00 2 1 vec=%h",
               result, op_count, result_valid, obs, model_vec());
    end
  endtask

  task automatic test_hold();
    tick(1, 0, 0, 8'h00, 2'b00);
    tick(0, 0, 1, 8'h7F, 2'b00);
    for (int i = 1; i < 20; i++) tick(0, 0, 1, $urandom_range(0, 255), 2'($urandom_range(0, 3)));
    tests_run++;
    if (A !== 8'h7F || state !== 3'b001 || B !== 8'h00 || obs !== model_vec()) begin
      tests_failed++;
      $display("FAIL hold_load: got A=%h st=%b B=%h expected 7F 001 00", A, state, B);
    end
    tick(0, 0, 0, 8'h00, 2'b00);
  endtask

  task automatic test_wrap();
    tick(1, 0, 0, 8'h00, 2'b00);
    for (int n = 1; n <= 16; n++) begin
      press($urandom_range(0, 255), 2'b00);
      press($urandom_range(0, 255), 2'b00);
      tick(0, 0, 1, 8'h00, 2'($urandom_range(0, 3)));
      tick(0, 0, 0, 8'h00, 2'b00);
      tests_run++;
      if (obs !== model_vec()) begin
        tests_failed++;
        $display("FAIL wrap_op %0d: got %h expected %h", n, obs, model_vec());
      end
      if (n == 15 || n == 16) begin
        tests_run++;
        if (op_count !== ((n == 16) ? 4'd0 : 4'd15)) begin
          tests_failed++;
          $display("FAIL wrap_count after %0d ops: got %0d expected %0d", n, op_count, n % 16);
        end
      end
    end
  endtask

  task automatic test_clear();
    tick(1, 0, 0, 8'h00, 2'b00);
    press(8'h11, 2'b00);
    press(8'h22, 2'b00);
    tick(0, 0, 1, 8'h00, 2'b10);
    tick(0, 0, 0, 8'h00, 2'b00);
    press(8'h44, 2'b00);
    press(8'h55, 2'b00);
    tick(0, 0, 1, 8'h00, 2'b11);
    tick(0, 1, 0, 8'h00, 2'b00);
    tests_run++;
    if (op_count !== 4'd1 || state !== 3'b000 || result_valid !== 1'b0 || A !== 8'h00 ||
        B !== 8'h00 || F !== 2'b00 || result !== 8'h00) begin
      tests_failed++;
      $display("FAIL clear_exec: got cnt=%0d st=%b v=%b A=%h B=%h F=%b res=%h expected 1 000 0 00 00 00 00",
               op_count, state, result_valid, A, B, F, result);
    end
    press(8'hAA, 2'b00);
    tick(0, 1, 1, 8'h55, 2'b00);
    tests_run++;
    if (state !== 3'b000 || A !== 8'h00 || B !== 8'h00 || F !== 2'b00 || op_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL clear_with_load: got st=%b A=%h B=%h F=%b cnt=%0d expected 000 00 00 00 1", state, A, B, F, op_count);
    end
    tick(0, 0, 1, 8'h66, 2'b00);
    tests_run++;
    if (state !== 3'b001 || A !== 8'h66) begin
      tests_failed++;
      $display("FAIL clear_held_load: got st=%b A=%h expected 001 66", state, A);
    end
    tick(1, 1, 1, 8'h77, 2'b00);
    tests_run++;
    if (obs !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_over_clear: got %h expected %h", obs, 35'h0);
    end
    tick(0, 0, 0, 8'h00, 2'b00);
  endtask

  task automatic test_random();
    logic r, c, l;
    tick(1, 0, 0, 8'h00, 2'b00);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 24) == 0);
      l = ($urandom_range(0, 1) == 1);
      tick(r, c, l, $urandom_range(0, 255), 2'($urandom_range(0, 3)));
      tests_run++;
      if (obs !== model_vec()) begin
        tests_failed++;
        $display("FAIL random cycle %0d: got %h expected %h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    reset = 1; clear = 0; load = 0; data_in = 0; op_in = 0;
    m_phase = 0; m_a = 0; m_b = 0; m_f = 0; m_res = 0; m_flag = 0; m_valid = 0; m_loadq = 0; m_cnt = 0;
    test_reset();
    test_basic();
    test_show_reload();
    test_hold();
    test_wrap();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
